// File: rtl/cra_pkg.sv
// rtl/cra_pkg.sv - shared microcode subroutine-stack constants and types
package cra_pkg;

   localparam int CRAM_ADR_W = 11;
   localparam int SBR_DEPTH  = 16;
   localparam int SBR_PTR_W  = 5;
   localparam int SBR_IDX_W  = 4;

   // Entry count of a full stack, typed to the pointer width for direct compares
   localparam logic [SBR_PTR_W-1:0] SBR_FULL = SBR_PTR_W'(SBR_DEPTH);

   // Decoded stack operation for one microinstruction advance
   typedef enum logic [1:0] {
      OP_NONE    = 2'd0,
      OP_PUSH    = 2'd1,
      OP_POP     = 2'd2,
      OP_REPLACE = 2'd3
   } sbr_op_e;

endpackage

// File: rtl/cra_sbr_ram.sv
// rtl/cra_sbr_ram.sv - 16x11 subroutine return-address storage
module cra_sbr_ram
   import cra_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_we,
   input  logic [SBR_IDX_W-1:0]   i_waddr,
   input  logic [0:CRAM_ADR_W-1]  i_wdata,
   input  logic [SBR_IDX_W-1:0]   i_raddr,
   output logic [0:CRAM_ADR_W-1]  o_rdata
);

   logic [0:CRAM_ADR_W-1] r_mem [SBR_DEPTH];

   // Single synchronous write port; contents are never reset
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cra_sbr_stack.sv
// rtl/cra_sbr_stack.sv - microcode subroutine return stack with sticky error flags
module cra_sbr_stack
   import cra_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   crmEn,
   input  logic [0:CRAM_ADR_W-1]  CRADR,
   input  logic                   CALL,
   input  logic                   force1777,
   input  logic                   ret,
   input  logic                   diagClear,
   output logic [0:CRAM_ADR_W-1]  sbrRet,
   output logic [SBR_PTR_W-1:0]   stackAdr,
   output logic                   stackOverflow,
   output logic                   stackUnderflow
);

   logic [SBR_PTR_W-1:0]  r_stack_adr;
   logic [0:CRAM_ADR_W-1] r_sbr_ret;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_push;
   logic                  w_pop;
   sbr_op_e               w_op;
   logic                  w_we;
   logic [SBR_IDX_W-1:0]  w_waddr;
   logic [SBR_IDX_W-1:0]  w_top_idx;
   logic [SBR_IDX_W-1:0]  w_below_idx;
   logic [0:CRAM_ADR_W-1] w_below_data;
   logic [SBR_PTR_W-1:0]  w_next_adr;
   logic [0:CRAM_ADR_W-1] w_next_ret;
   logic                  w_set_ovf;
   logic                  w_set_unf;

   // A trap force is an implicit call and suppresses any return decode
   assign w_push = crmEn & (CALL | force1777);
   assign w_pop  = crmEn & ret & ~force1777;

   // Modulo-16 arithmetic is exact here: a full stack (16) maps to 0, so 16-1=15 and 16-2=14
   assign w_top_idx   = r_stack_adr[SBR_IDX_W-1:0] - 4'd1;
   assign w_below_idx = r_stack_adr[SBR_IDX_W-1:0] - 4'd2;

   cra_sbr_ram u_ram (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (CRADR),
      .i_raddr (w_below_idx),
      .o_rdata (w_below_data)
   );

   // Classify the operation; call+return on an empty stack degrades to a plain call
   always_comb begin
      w_op = OP_NONE;
      if (w_push && w_pop && (r_stack_adr != '0)) begin
         w_op = OP_REPLACE;
      end else if (w_push) begin
         w_op = OP_PUSH;
      end else if (w_pop) begin
         w_op = OP_POP;
      end
   end

   // Next pointer, next top-of-stack copy, RAM write and error set strobes
   always_comb begin
      w_next_adr = r_stack_adr;
      w_next_ret = r_sbr_ret;
      w_we       = 1'b0;
      w_waddr    = r_stack_adr[SBR_IDX_W-1:0];
      w_set_ovf  = 1'b0;
      w_set_unf  = 1'b0;
      case (w_op)
         OP_REPLACE: begin
            w_we       = ~reset;
            w_waddr    = w_top_idx;
            w_next_ret = CRADR;
         end
         OP_PUSH: begin
            if (r_stack_adr != SBR_FULL) begin
               w_we       = ~reset;
               w_next_adr = r_stack_adr + 5'd1;
               w_next_ret = CRADR;
            end else begin
               w_set_ovf = 1'b1;
            end
         end
         OP_POP: begin
            if (r_stack_adr >= 5'd2) begin
               w_next_adr = r_stack_adr - 5'd1;
               w_next_ret = w_below_data;
            end else begin
               w_next_adr = '0;
               w_next_ret = '0;
               w_set_unf  = (r_stack_adr == '0);
            end
         end
         default: begin
         end
      endcase
   end

   // Pointer and cached top-of-stack; reset overrides any operation
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stack_adr <= '0;
         r_sbr_ret   <= '0;
      end else begin
         r_stack_adr <= w_next_adr;
         r_sbr_ret   <= w_next_ret;
      end
   end

   // Sticky error flags; a new error in the clearing cycle wins over the clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_set_ovf | (r_overflow & ~diagClear);
         r_underflow <= w_set_unf | (r_underflow & ~diagClear);
      end
   end

   assign sbrRet         = r_sbr_ret;
   assign stackAdr       = r_stack_adr;
   assign stackOverflow  = r_overflow;
   assign stackUnderflow = r_underflow;

endmodule

// File: tb/tb_cra_sbr_stack.sv
// tb/tb_cra_sbr_stack.sv - scoreboard bench for the microcode subroutine stack
module tb_cra_sbr_stack;

   typedef struct packed {
      logic [4:0]  adr;
      logic [10:0] ret;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        crmEn;
   logic [0:10] CRADR;
   logic        CALL;
   logic        force1777;
   logic        ret;
   logic        diagClear;
   logic [0:10] sbrRet;
   logic [4:0]  stackAdr;
   logic        stackOverflow;
   logic        stackUnderflow;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   cra_sbr_stack dut (
      .clk            (clk),
      .reset          (reset),
      .crmEn          (crmEn),
      .CRADR          (CRADR),
      .CALL           (CALL),
      .force1777      (force1777),
      .ret            (ret),
      .diagClear      (diagClear),
      .sbrRet         (sbrRet),
      .stackAdr       (stackAdr),
      .stackOverflow  (stackOverflow),
      .stackUnderflow (stackUnderflow)
   );

   always #5 clk = ~clk;

   // Apply one microcode cycle and sample 1 time unit after the rising edge
   task automatic cycle(input logic en, input logic c, input logic r, input logic f,
                        input logic dc, input logic rst, input logic [10:0] a);
      crmEn = en; CALL = c; ret = r; force1777 = f; diagClear = dc; reset = rst; CRADR = a;
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int adr, input logic [10:0] r, input logic o, input logic u);
      exp_t e;
      e.adr = 5'(adr); e.ret = r; e.ovf = o; e.unf = u;
      return e;
   endfunction

   task automatic test_reset();
      exp_t e, got;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(mk(0, 11'o0, 1'b0, 1'b0));
         cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'o1234);
         got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
         e = exp_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL reset[%0d]: got adr=%0d ret=%o ovf=%b unf=%b, want adr=%0d ret=%o ovf=%b unf=%b",
                     i, got.adr, got.ret, got.ovf, got.unf, e.adr, e.ret, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_push_unwind();
      exp_t e, got;
      logic [10:0] a [4] = '{11'o100, 11'o200, 11'o0, 11'o0};
      logic        r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_q.push_back(mk(1, 11'o100, 1'b0, 1'b0));
      exp_q.push_back(mk(2, 11'o200, 1'b0, 1'b0));
      exp_q.push_back(mk(1, 11'o100, 1'b0, 1'b0));
      exp_q.push_back(mk(0, 11'o0,   1'b0, 1'b0));
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, ~r[i], r[i], 1'b0, 1'b0, 1'b0, a[i]);
         got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
         e = exp_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL push_unwind[%0d]: got adr=%0d ret=%o ovf=%b unf=%b, want adr=%0d ret=%o ovf=%b unf=%b",
                     i, got.adr, got.ret, got.ovf, got.unf, e.adr, e.ret, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_overflow();
      exp_t e, got;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'o0);
      for (int i = 1; i <= 33; i++) begin
         if (i <= 16)      exp_q.push_back(mk(i, 11'(i), 1'b0, 1'b0));
         else if (i == 17) exp_q.push_back(mk(16, 11'd16, 1'b1, 1'b0));
         else              exp_q.push_back(mk(33 - i, 11'(33 - i), 1'b1, 1'b0));
         if (i <= 17) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'(i));
         else         cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'o0);
         got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
         e = exp_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL overflow[%0d]: got adr=%0d ret=%0d ovf=%b unf=%b, want adr=%0d ret=%0d ovf=%b unf=%b",
                     i, got.adr, got.ret, got.ovf, got.unf, e.adr, e.ret, e.ovf, e.unf);
         end
      end
      exp_q.push_back(mk(0, 11'o0, 1'b0, 1'b0));
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'o0);
      got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL overflow_clear: got ovf=%b adr=%0d, want ovf=%b adr=%0d", got.ovf, got.adr, e.ovf, e.adr);
      end
   endtask

   task automatic test_underflow();
      exp_t e, got;
      logic en [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic dc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      exp_q.push_back(mk(0, 11'o0, 1'b0, 1'b1));
      exp_q.push_back(mk(0, 11'o0, 1'b0, 1'b0));
      exp_q.push_back(mk(0, 11'o0, 1'b0, 1'b1));
      exp_q.push_back(mk(0, 11'o0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) begin
         cycle(en[i], 1'b0, 1'b1, 1'b0, dc[i], 1'b0, 11'o0);
         got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
         e = exp_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL underflow[%0d]: got adr=%0d ret=%o ovf=%b unf=%b, want adr=%0d ret=%o ovf=%b unf=%b",
                     i, got.adr, got.ret, got.ovf, got.unf, e.adr, e.ret, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_combined();
      exp_t e, got;
      //                en    call  ret   force
      logic v [12][4] = '{'{1'b1, 1'b1, 1'b1, 1'b0},   // call+ret on empty: plain call
                          '{1'b1, 1'b0, 1'b1, 1'b0},
                          '{1'b1, 1'b1, 1'b0, 1'b0},
                          '{1'b1, 1'b1, 1'b0, 1'b0},
                          '{1'b1, 1'b1, 1'b0, 1'b0},
                          '{1'b1, 1'b1, 1'b1, 1'b0},   // replace top
                          '{1'b1, 1'b0, 1'b1, 1'b1},   // force beats ret
                          '{1'b0, 1'b1, 1'b0, 1'b0},
                          '{1'b0, 1'b0, 1'b1, 1'b0},
                          '{1'b0, 1'b0, 1'b0, 1'b1},
                          '{1'b1, 1'b0, 1'b1, 1'b0},
                          '{1'b1, 1'b0, 1'b1, 1'b0}};
      logic [10:0] a [12] = '{11'o55, 11'o0, 11'o10, 11'o20, 11'o30, 11'o300, 11'o1777,
                              11'o7, 11'o7, 11'o7, 11'o0, 11'o0};
      exp_q.push_back(mk(1, 11'o55,   1'b0, 1'b0));
      exp_q.push_back(mk(0, 11'o0,    1'b0, 1'b0));
      exp_q.push_back(mk(1, 11'o10,   1'b0, 1'b0));
      exp_q.push_back(mk(2, 11'o20,   1'b0, 1'b0));
      exp_q.push_back(mk(3, 11'o30,   1'b0, 1'b0));
      exp_q.push_back(mk(3, 11'o300,  1'b0, 1'b0));
      exp_q.push_back(mk(4, 11'o1777, 1'b0, 1'b0));
      exp_q.push_back(mk(4, 11'o1777, 1'b0, 1'b0));
      exp_q.push_back(mk(4, 11'o1777, 1'b0, 1'b0));
      exp_q.push_back(mk(4, 11'o1777, 1'b0, 1'b0));
      exp_q.push_back(mk(3, 11'o300,  1'b0, 1'b0));
      exp_q.push_back(mk(2, 11'o20,   1'b0, 1'b0));
      for (int i = 0; i < 12; i++) begin
         cycle(v[i][0], v[i][1], v[i][2], v[i][3], 1'b0, 1'b0, a[i]);
         got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
         e = exp_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL combined[%0d]: got adr=%0d ret=%o ovf=%b unf=%b, want adr=%0d ret=%o ovf=%b unf=%b",
                     i, got.adr, got.ret, got.ovf, got.unf, e.adr, e.ret, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e, got;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'o0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'o0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'(11'o400 + i));
      exp_q.push_back(mk(5, 11'o404, 1'b0, 1'b1));
      exp_q.push_back(mk(0, 11'o0,   1'b0, 1'b0));
      exp_q.push_back(mk(0, 11'o0,   1'b0, 1'b1));
      for (int i = 0; i < 3; i++) begin
         if (i == 1)      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 11'o666);
         else if (i == 2) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'o0);
         got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
         e = exp_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL reset_mid[%0d]: got adr=%0d ret=%o ovf=%b unf=%b, want adr=%0d ret=%o ovf=%b unf=%b",
                     i, got.adr, got.ret, got.ovf, got.unf, e.adr, e.ret, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e, got;
      logic [10:0] stk[$];
      logic [10:0] m_ret;
      logic        m_ovf, m_unf;
      logic        en, c, r, f, dc, psh, pp;
      logic [10:0] a;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'o0);
      m_ret = '0; m_ovf = 1'b0; m_unf = 1'b0;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 7) != 0);
         c  = ($urandom_range(0, 2) == 0) || (i < 60 && $urandom_range(0, 1) == 0);
         r  = ($urandom_range(0, 2) == 0);
         f  = ($urandom_range(0, 15) == 0);
         dc = ($urandom_range(0, 11) == 0);
         a  = 11'($urandom);
         psh = en & (c | f);
         pp  = en & r & ~f;
         m_ovf = m_ovf & ~dc;
         m_unf = m_unf & ~dc;
         if (psh && pp && stk.size() > 0) begin
            stk[stk.size() - 1] = a;
            m_ret = a;
         end else if (psh) begin
            if (stk.size() < 16) begin stk.push_back(a); m_ret = a; end
            else m_ovf = 1'b1;
         end else if (pp) begin
            if (stk.size() == 0) m_unf = 1'b1;
            else void'(stk.pop_back());
            m_ret = (stk.size() > 0) ? stk[stk.size() - 1] : 11'o0;
         end
         exp_q.push_back(mk(stk.size(), m_ret, m_ovf, m_unf));
         cycle(en, c, r, f, dc, 1'b0, a);
         got = {stackAdr, sbrRet, stackOverflow, stackUnderflow};
         e = exp_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: got adr=%0d ret=%o ovf=%b unf=%b, want adr=%0d ret=%o ovf=%b unf=%b",
                     i, got.adr, got.ret, got.ovf, got.unf, e.adr, e.ret, e.ovf, e.unf);
         end
      end
   endtask

   initial begin
      reset = 1'b1; crmEn = 1'b0; CALL = 1'b0; ret = 1'b0;
      force1777 = 1'b0; diagClear = 1'b0; CRADR = '0;
      test_reset();
      test_push_unwind();
      test_overflow();
      test_underflow();
      test_combined();
      test_reset_mid();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
